// File: rtl/dcache_resp.sv
// Direct-mapped, one-word-line, write-through / write-no-allocate data cache responder.
// Define DCACHE_PERF_CNT_EN to add the perf_hit_cnt / perf_miss_cnt outputs.
module dcache_resp #(
    parameter int unsigned INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_mem_rvalid,
    input  logic        EX_mem_wvalid,
    input  logic [31:0] EX_mem_addr,
    input  logic [2:0]  EX_mem_type,
    input  logic [31:0] EX_mem_wdata,
    output logic        MEM_mem_rready,
    output logic        MEM_mem_wready,
    output logic [31:0] MEM_mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0] perf_hit_cnt,
    output logic [31:0] perf_miss_cnt
`endif
);

    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 32 - INDEX_BITS - 2;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_MISS = 3'd1;
    localparam logic [2:0] RD_DONE = 3'd2;
    localparam logic [2:0] WR_BUS  = 3'd3;
    localparam logic [2:0] WR_DONE = 3'd4;

    logic [2:0]          state, state_next;
    logic                req_rd, req_wr;
    logic [31:0]         req_addr;
    logic [2:0]          req_type;
    logic [31:0]         req_wdata;

    logic [LINES-1:0]    valid_bits;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    // Line contents read at capture time, consumed in the MEM cycle.
    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    logic [31:0]         rd_data;

    logic [INDEX_BITS-1:0] ex_idx, req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  hit, capture, rdata_en, fill, store_hit;
    logic                  is_b, is_h;
    logic [1:0]            off;
    logic [3:0]            wstrb_c;
    logic [31:0]           wdata_rep, merged, shifted, load_ext;

    assign ex_idx  = EX_mem_addr[INDEX_BITS+1:2];
    assign req_idx = req_addr[INDEX_BITS+1:2];
    assign req_tag = req_addr[31:INDEX_BITS+2];
    assign hit     = rd_valid && (rd_tag == req_tag);
    assign capture = MEM_mem_rready | MEM_mem_wready;
    assign fill      = (state == RD_MISS) && mem_ack;
    assign store_hit = (state == IDLE) && req_wr && hit;

    // Lane decode; misaligned W/H addresses are forced aligned.
    assign is_b = (req_type[1:0] == 2'b10);
    assign is_h = (req_type[1:0] == 2'b01);
    assign off  = is_b ? req_addr[1:0] : (is_h ? {req_addr[1], 1'b0} : 2'b00);

    always_comb begin
        wstrb_c   = 4'b1111;
        wdata_rep = req_wdata;
        if (is_b) begin
            wstrb_c   = 4'b0001 << off;
            wdata_rep = {4{req_wdata[7:0]}};
        end else if (is_h) begin
            wstrb_c   = 4'b0011 << off;
            wdata_rep = {2{req_wdata[15:0]}};
        end
    end

    always_comb begin
        merged = rd_data;
        for (int i = 0; i < 4; i++) begin
            if (wstrb_c[i]) merged[8*i +: 8] = wdata_rep[8*i +: 8];
        end
    end

    always_comb begin
        shifted = rd_data >> {off, 3'b000};
        if (is_b)      load_ext = {{24{~req_type[2] & shifted[7]}}, shifted[7:0]};
        else if (is_h) load_ext = {{16{~req_type[2] & shifted[15]}}, shifted[15:0]};
        else           load_ext = rd_data;
    end

    always_comb begin
        state_next     = state;
        MEM_mem_rready = 1'b0;
        MEM_mem_wready = 1'b0;
        rdata_en       = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        case (state)
            IDLE: begin
                if (req_wr) begin
                    state_next = WR_BUS;
                end else if (req_rd) begin
                    if (hit) begin
                        MEM_mem_rready = 1'b1;
                        rdata_en       = 1'b1;
                    end else begin
                        state_next = RD_MISS;
                    end
                end else begin
                    MEM_mem_rready = 1'b1;
                    MEM_mem_wready = 1'b1;
                end
            end
            RD_MISS: begin
                mem_req = 1'b1;
                if (mem_ack) state_next = RD_DONE;
            end
            RD_DONE: begin
                MEM_mem_rready = 1'b1;
                rdata_en       = 1'b1;
                state_next     = IDLE;
            end
            WR_BUS: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) state_next = WR_DONE;
            end
            WR_DONE: begin
                MEM_mem_wready = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus fields derive from the frozen MEM request, so they hold steady until mem_ack.
    assign MEM_mem_rdata = rdata_en ? load_ext : 32'h0;
    assign mem_addr      = mem_req ? {req_addr[31:2], 2'b00} : 32'h0;
    assign mem_wdata     = mem_we ? wdata_rep : 32'h0;
    assign mem_wstrb     = mem_we ? wstrb_c : 4'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_rd     <= 1'b0;
            req_wr     <= 1'b0;
            req_addr   <= 32'h0;
            req_type   <= 3'h0;
            req_wdata  <= 32'h0;
            valid_bits <= '0;
            rd_valid   <= 1'b0;
            rd_tag     <= '0;
            rd_data    <= 32'h0;
        end else begin
            state <= state_next;
            if (capture) begin
                req_rd    <= EX_mem_rvalid & ~EX_mem_wvalid;
                req_wr    <= EX_mem_wvalid;
                req_addr  <= EX_mem_addr;
                req_type  <= EX_mem_type;
                req_wdata <= EX_mem_wdata;
                rd_valid  <= valid_bits[ex_idx];
                rd_tag    <= tag_mem[ex_idx];
                rd_data   <= data_mem[ex_idx];
            end else if (fill) begin
                valid_bits[req_idx] <= 1'b1;
                rd_data             <= mem_rdata;
            end
        end
    end

    // Array writes never coincide with a capture edge, so the captured read is never stale.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill) begin
                tag_mem[req_idx]  <= req_tag;
                data_mem[req_idx] <= mem_rdata;
            end else if (store_hit) begin
                data_mem[req_idx] <= merged;
            end
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= 32'h0;
            miss_cnt <= 32'h0;
        end else begin
            if (state == IDLE && req_rd && hit)  hit_cnt  <= hit_cnt + 32'h1;
            if (state == IDLE && req_rd && !hit) miss_cnt <= miss_cnt + 32'h1;
        end
    end

    assign perf_hit_cnt  = hit_cnt;
    assign perf_miss_cnt = miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_resp.sv
// Self-checking bench for dcache_resp: directed scenarios plus randomized loads/stores
// against a word-memory / line-presence reference model.
module tb_dcache_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        EX_mem_rvalid, EX_mem_wvalid;
    logic [31:0] EX_mem_addr;
    logic [2:0]  EX_mem_type;
    logic [31:0] EX_mem_wdata;
    logic        MEM_mem_rready, MEM_mem_wready;
    logic [31:0] MEM_mem_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dcache_resp #(.INDEX_BITS(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .EX_mem_rvalid  (EX_mem_rvalid),
        .EX_mem_wvalid  (EX_mem_wvalid),
        .EX_mem_addr    (EX_mem_addr),
        .EX_mem_type    (EX_mem_type),
        .EX_mem_wdata   (EX_mem_wdata),
        .MEM_mem_rready (MEM_mem_rready),
        .MEM_mem_wready (MEM_mem_wready),
        .MEM_mem_rdata  (MEM_mem_rdata),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata)
    );

    int checks   = 0;
    int failures = 0;

    // Bus-side memory (updated with whatever the DUT writes) and reference memory (updated
    // from store semantics); they diverge if the DUT writes the wrong lanes.
    logic [31:0] busmem [bit [29:0]];
    logic [31:0] refmem [bit [29:0]];
    logic        cm_valid [256];
    logic [21:0] cm_tag   [256];

    int          bus_lat   = 1;
    int          bus_cnt   = 0;
    int          ack_count = 0;
    logic        last_we;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_wstrb;

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return {wa[15:0], ~wa[15:0]} ^ 32'h3c5a_96e1;
    endfunction

    function automatic logic [31:0] bus_word(input logic [29:0] wa);
        if (busmem.exists(wa)) return busmem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [31:0] ref_word(input logic [29:0] wa);
        if (refmem.exists(wa)) return refmem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] t);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*int'(a[1:0]) +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (t)
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            3'b010:  return {{24{b[7]}}, b};
            3'b110:  return {24'h0, b};
            default: return w;
        endcase
    endfunction

    // Bus responder: acks on the bus_lat-th cycle of each request.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            if (mem_req && !rst) begin
                bus_cnt++;
                if (bus_cnt >= bus_lat) begin
                    logic [31:0] w;
                    bus_cnt    = 0;
                    mem_ack    = 1'b1;
                    ack_count++;
                    last_we    = mem_we;
                    last_addr  = mem_addr;
                    last_wdata = mem_wdata;
                    last_wstrb = mem_wstrb;
                    w = bus_word(mem_addr[31:2]);
                    if (mem_we) begin
                        for (int k = 0; k < 4; k++)
                            if (mem_wstrb[k]) w[8*k +: 8] = mem_wdata[8*k +: 8];
                        busmem[mem_addr[31:2]] = w;
                    end else begin
                        mem_rdata = w;
                    end
                end
            end else begin
                bus_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_model;
        for (int i = 0; i < 256; i++) begin
            cm_valid[i] = 1'b0;
            cm_tag[i]   = 22'h0;
        end
    endtask

    task automatic issue(input logic rv, input logic wv, input logic [31:0] a,
                         input logic [2:0] t, input logic [31:0] wd);
        EX_mem_rvalid = rv;
        EX_mem_wvalid = wv;
        EX_mem_addr   = a;
        EX_mem_type   = t;
        EX_mem_wdata  = wd;
        @(posedge clk);
        #1;
        EX_mem_rvalid = 1'b0;
        EX_mem_wvalid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input logic is_st, output logic [31:0] rd,
                             output int stalls);
        logic done;
        done   = 1'b0;
        stalls = 0;
        rd     = 32'hx;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            #1;
            if (is_st ? MEM_mem_wready : MEM_mem_rready) begin
                rd   = MEM_mem_rdata;
                done = 1'b1;
            end else begin
                stalls++;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout, ready never rose within 200 cycles", nm);
        end
    endtask

    task automatic do_op(input string nm, input logic rv, input logic wv, input logic [31:0] a,
                         input logic [2:0] t, input logic [31:0] wd, input int lat,
                         output logic [31:0] got, output int stalls);
        logic        is_st, exp_hit;
        logic [29:0] wa;
        logic [21:0] tg;
        int          idx, base, n, acks0, exp_stall;
        logic [31:0] w, exp_rd, exp_wd;
        logic [3:0]  exp_strb;
        is_st = wv;
        wa    = a[31:2];
        tg    = a[31:10];
        idx   = int'(a[9:2]);
        base  = 0;
        n     = 4;
        if (t[1:0] == 2'b10) begin
            base = int'(a[1:0]);
            n    = 1;
        end else if (t[1:0] == 2'b01) begin
            base = a[1] ? 2 : 0;
            n    = 2;
        end
        exp_hit  = !is_st && cm_valid[idx] && (cm_tag[idx] == tg);
        exp_rd   = 32'h0;
        exp_wd   = 32'h0;
        exp_strb = 4'h0;
        if (is_st) begin
            w = ref_word(wa);
            for (int k = 0; k < n; k++) begin
                w[8*(base+k) +: 8] = wd[8*k +: 8];
                exp_strb[base+k]   = 1'b1;
            end
            for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = wd[8*(k % n) +: 8];
            refmem[wa] = w;
        end else begin
            exp_rd        = ref_load(ref_word(wa), a, t);
            cm_valid[idx] = 1'b1;
            cm_tag[idx]   = tg;
        end
        exp_stall = exp_hit ? 0 : lat + 1;

        bus_lat = lat;
        acks0   = ack_count;
        issue(rv, wv, a, t, wd);
        wait_done(nm, is_st, got, stalls);

        checks++;
        if (stalls !== exp_stall) begin
            failures++;
            $display("FAIL %s stall a=%h: got %0d want %0d", nm, a, stalls, exp_stall);
        end
        checks++;
        if (ack_count - acks0 !== (exp_hit ? 0 : 1)) begin
            failures++;
            $display("FAIL %s bus_txns a=%h: got %0d want %0d", nm, a, ack_count - acks0,
                     exp_hit ? 0 : 1);
        end
        if (!is_st) begin
            checks++;
            if (got !== exp_rd) begin
                failures++;
                $display("FAIL %s rdata a=%h t=%b: got %h want %h", nm, a, t, got, exp_rd);
            end
        end
        if (!exp_hit) begin
            checks++;
            if (last_we !== is_st || last_addr !== {wa, 2'b00}) begin
                failures++;
                $display("FAIL %s bus_cmd: got we=%b addr=%h want we=%b addr=%h", nm,
                         last_we, last_addr, is_st, {wa, 2'b00});
            end
        end
        if (is_st) begin
            checks++;
            if (last_wstrb !== exp_strb || last_wdata !== exp_wd) begin
                failures++;
                $display("FAIL %s bus_wr: got strb=%b wdata=%h want strb=%b wdata=%h", nm,
                         last_wstrb, last_wdata, exp_strb, exp_wd);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        EX_mem_rvalid = 1'b0;
        EX_mem_wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (MEM_mem_rready !== 1'b1 || MEM_mem_wready !== 1'b1 || mem_req !== 1'b0 ||
                MEM_mem_rdata !== 32'h0 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin
                failures++;
                $display("FAIL reset_idle cyc %0d: got rr=%b wr=%b req=%b rdata=%h want 1 1 0 0",
                         i, MEM_mem_rready, MEM_mem_wready, mem_req, MEM_mem_rdata);
            end
        end
    endtask

    task automatic test_cold_miss_and_hit;
        logic [31:0] got;
        int          st;
        refmem[30'h40] = 32'hDEADBEEF;
        busmem[30'h40] = 32'hDEADBEEF;
        do_op("cold_ld", 1'b1, 1'b0, 32'h100, 3'b000, 32'h0, 3, got, st);
        checks++;
        if (st !== 4 || got !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL cold_ld_const: got stall=%0d rdata=%h want 4 DEADBEEF", st, got);
        end
        do_op("warm_ld", 1'b1, 1'b0, 32'h100, 3'b000, 32'h0, 3, got, st);
        checks++;
        if (st !== 0) begin
            failures++;
            $display("FAIL warm_ld_const: got stall=%0d want 0", st);
        end
    endtask

    task automatic test_load_extend;
        logic [31:0] got;
        int          st;
        do_op("ld_b", 1'b1, 1'b0, 32'h103, 3'b010, 32'h0, 2, got, st);
        checks++;
        if (got !== 32'hFFFFFFDE) begin
            failures++;
            $display("FAIL ld_b_const: got %h want FFFFFFDE", got);
        end
        do_op("ld_bu", 1'b1, 1'b0, 32'h103, 3'b110, 32'h0, 2, got, st);
        checks++;
        if (got !== 32'h000000DE) begin
            failures++;
            $display("FAIL ld_bu_const: got %h want 000000DE", got);
        end
        do_op("ld_h", 1'b1, 1'b0, 32'h102, 3'b001, 32'h0, 2, got, st);
        checks++;
        if (got !== 32'hFFFFDEAD) begin
            failures++;
            $display("FAIL ld_h_const: got %h want FFFFDEAD", got);
        end
    endtask

    task automatic test_store;
        logic [31:0] got;
        int          st;
        do_op("st_b_hit", 1'b0, 1'b1, 32'h101, 3'b010, 32'h55, 2, got, st);
        checks++;
        if (last_wstrb !== 4'b0010 || last_wdata !== 32'h55555555 || st !== 3) begin
            failures++;
            $display("FAIL st_b_const: got strb=%b wdata=%h stall=%0d want 0010 55555555 3",
                     last_wstrb, last_wdata, st);
        end
        do_op("ld_merged", 1'b1, 1'b0, 32'h100, 3'b000, 32'h0, 2, got, st);
        checks++;
        if (got !== 32'hDEAD55EF || st !== 0) begin
            failures++;
            $display("FAIL ld_merged_const: got %h stall=%0d want DEAD55EF 0", got, st);
        end
        do_op("st_w_nocache", 1'b0, 1'b1, 32'h400, 3'b000, 32'h1234_5678, 1, got, st);
        do_op("ld_no_alloc", 1'b1, 1'b0, 32'h400, 3'b000, 32'h0, 1, got, st);
        checks++;
        if (st !== 2 || got !== 32'h1234_5678) begin
            failures++;
            $display("FAIL ld_no_alloc_const: got stall=%0d rdata=%h want 2 12345678", st, got);
        end
    endtask

    task automatic test_conflict;
        logic [31:0] got;
        int          st;
        do_op("cf_a", 1'b1, 1'b0, 32'h100, 3'b000, 32'h0, 1, got, st);
        do_op("cf_b", 1'b1, 1'b0, 32'h500, 3'b000, 32'h0, 1, got, st);
        checks++;
        if (st !== 2) begin
            failures++;
            $display("FAIL cf_b_miss: got stall=%0d want 2", st);
        end
        do_op("cf_a_again", 1'b1, 1'b0, 32'h100, 3'b000, 32'h0, 1, got, st);
        checks++;
        if (st !== 2) begin
            failures++;
            $display("FAIL cf_evicted: got stall=%0d want 2", st);
        end
        // Simultaneous load+store request: the store wins.
        do_op("both_valid", 1'b1, 1'b1, 32'h100, 3'b001, 32'hABCD, 2, got, st);
    endtask

    task automatic test_reset_mid_miss;
        logic [31:0] got;
        int          st;
        do_op("rmm_warm", 1'b1, 1'b0, 32'h100, 3'b000, 32'h0, 2, got, st);
        do_op("rmm_hit", 1'b1, 1'b0, 32'h100, 3'b000, 32'h0, 2, got, st);
        bus_lat = 50;
        issue(1'b1, 1'b0, 32'h904, 3'b000, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rmm_req_pending: got mem_req=%b want 1", mem_req);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || MEM_mem_rready !== 1'b1 || MEM_mem_wready !== 1'b1) begin
            failures++;
            $display("FAIL rmm_after_rst: got req=%b rr=%b wr=%b want 0 1 1",
                     mem_req, MEM_mem_rready, MEM_mem_wready);
        end
        rst = 1'b0;
        clear_model();
        do_op("rmm_relookup", 1'b1, 1'b0, 32'h100, 3'b000, 32'h0, 2, got, st);
        checks++;
        if (st !== 3) begin
            failures++;
            $display("FAIL rmm_line_lost: got stall=%0d want 3", st);
        end
    endtask

    task automatic test_random;
        logic [2:0]  lt [5];
        logic [31:0] a, wd, got;
        logic [2:0]  t;
        logic        rv, wv;
        int          r, st;
        lt = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110};
        for (int i = 0; i < 250; i++) begin
            a = 32'h2000 + 32'($urandom_range(0, 2)) * 32'h400 +
                32'($urandom_range(0, 3)) * 32'd4 + 32'($urandom_range(0, 3));
            wd = $urandom;
            r  = int'($urandom_range(0, 9));
            if (r < 4) begin
                wv = 1'b1;
                rv = (r == 0);
                t  = lt[$urandom_range(0, 2)];
            end else begin
                wv = 1'b0;
                rv = 1'b1;
                t  = lt[$urandom_range(0, 4)];
            end
            do_op("rand", rv, wv, a, t, wd, int'($urandom_range(1, 4)), got, st);
        end
    endtask

    initial begin
        rst           = 1'b1;
        EX_mem_rvalid = 1'b0;
        EX_mem_wvalid = 1'b0;
        EX_mem_addr   = 32'h0;
        EX_mem_type   = 3'b000;
        EX_mem_wdata  = 32'h0;
        test_reset();
        test_cold_miss_and_hit();
        test_load_extend();
        test_store();
        test_conflict();
        test_reset_mid_miss();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
